// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of a synchronous instruction memory.
// A skid register absorbs the one response already in flight when the
// downstream stage stalls, so no fetched address is dropped or repeated.
module fetch_unit #(
  parameter int ADDR_W = 9,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_dout,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              valid_out,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {FILL, RUN, SKID} state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   resp_pc_q, resp_pc_d;
  logic [INST_W-1:0]   skid_inst_q, skid_inst_d;
  logic [ADDR_W-1:0]   skid_pc_q, skid_pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                valid_q, valid_d;
  logic [15:0]         count_q, count_d;
  logic                out_accepts;

  assign imem_addr   = fetch_pc_q;
  assign inst_out    = inst_q;
  assign pc_out      = pc_q;
  assign valid_out   = valid_q;
  assign fetch_count = count_q;
  assign out_accepts = !stall || !valid_q;

  // Next-state and datapath selection; redirect overrides everything but reset.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    count_d     = count_q;
    if (redirect) begin
      // Any in-flight response or buffered instruction is simply abandoned.
      fetch_pc_d = redirect_pc;
      valid_d    = 1'b0;
      state_d    = FILL;
    end else begin
      case (state_q)
        FILL: begin
          resp_pc_d  = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_ONE;
          state_d    = RUN;
        end
        RUN: begin
          if (out_accepts) begin
            inst_d     = imem_dout;
            pc_d       = resp_pc_q;
            valid_d    = 1'b1;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
            resp_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_ONE;
          end else begin
            // Memory data is only valid this one cycle, so park it.
            skid_inst_d = imem_dout;
            skid_pc_d   = resp_pc_q;
            state_d     = SKID;
          end
        end
        SKID: begin
          // Address is held, so the memory re-reads fetch_pc each cycle and
          // its data is valid again the cycle after we leave SKID.
          if (!stall) begin
            inst_d     = skid_inst_q;
            pc_d       = skid_pc_q;
            valid_d    = 1'b1;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
            resp_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_ONE;
            state_d    = RUN;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= FILL;
      fetch_pc_q  <= '0;
      resp_pc_q   <= '0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
      inst_q      <= '0;
      pc_q        <= '0;
      valid_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
    end
  end

endmodule
